// File: rtl/mod_counter_monitor.sv
// Modulo up/down counter (load > en > hold) with a built-in bounded-value checker.
// Latency: count/wrap/load_err update one clock after the request; violation is combinational.
// Backpressure: none; the counter accepts a command every cycle.
module mod_counter_monitor #(
    parameter int WIDTH  = 5,
    parameter int MODULO = 23,
    parameter int BOUND  = 10,
    parameter int VCNT_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic              up,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_value,
    input  logic              clear_viol,
    output logic [WIDTH-1:0]  count,
    output logic              wrap,
    output logic              load_err,
    output logic              check_active,
    output logic              violation,
    output logic              violation_sticky,
    output logic [VCNT_W-1:0] viol_count
);

    generate
        if (MODULO < 2 || MODULO > (1 << WIDTH)) begin : g_bad_modulo
            $error("mod_counter_monitor: MODULO out of range 2..2**WIDTH");
        end
        if (BOUND < 1 || BOUND > (1 << WIDTH)) begin : g_bad_bound
            $error("mod_counter_monitor: BOUND out of range 1..2**WIDTH");
        end
    endgenerate

    // Comparisons are done one bit wider so MODULO/BOUND == 2**WIDTH stay representable.
    localparam logic [WIDTH:0]   MOD_W   = (WIDTH+1)'(MODULO);
    localparam logic [WIDTH:0]   BOUND_W = (WIDTH+1)'(BOUND);
    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULO - 1);

    logic armed;
    logic prev_nz;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else if (load) begin
            wrap <= 1'b0;
            if ({1'b0, load_value} < MOD_W) begin
                count    <= load_value;
                load_err <= 1'b0;
            end else begin
                count    <= '0;
                load_err <= 1'b1;
            end
        end else if (en) begin
            load_err <= 1'b0;
            if (up) begin
                if (count == MAX_CNT) begin
                    count <= '0;
                    wrap  <= 1'b1;
                end else begin
                    count <= count + WIDTH'(1);
                    wrap  <= 1'b0;
                end
            end else begin
                if (count == '0) begin
                    count <= MAX_CNT;
                    wrap  <= 1'b1;
                end else begin
                    count <= count - WIDTH'(1);
                    wrap  <= 1'b0;
                end
            end
        end else begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end
    end

    // armed is only ever written by reset, so it stays unknown until the first reset arrives.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            armed <= 1'b1;
        end else begin
            armed <= armed;
        end
    end

    assign check_active = armed & reset;
    assign violation    = check_active & prev_nz & ({1'b0, count} >= BOUND_W);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_nz          <= 1'b0;
            violation_sticky <= 1'b0;
            viol_count       <= '0;
        end else begin
            prev_nz <= |count;
            if (violation) begin
                // A violation coinciding with a clear restarts the tally at one.
                violation_sticky <= 1'b1;
                if (clear_viol) begin
                    viol_count <= VCNT_W'(1);
                end else if (viol_count != '1) begin
                    viol_count <= viol_count + VCNT_W'(1);
                end
            end else if (clear_viol) begin
                violation_sticky <= 1'b0;
                viol_count       <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mod_counter_monitor.sv
// Directed bench for mod_counter_monitor: a behavioural model compared every cycle,
// plus literal expectations at the interesting points; a second instance uses VCNT_W=2.
module tb_mod_counter_monitor;

    localparam int WIDTH  = 5;
    localparam int MOD    = 23;
    localparam int BOUND  = 10;

    logic             clock;
    logic             reset;
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             clear_viol;

    logic [WIDTH-1:0] count,  s_count;
    logic             wrap,   s_wrap;
    logic             load_err, s_load_err;
    logic             check_active, s_check_active;
    logic             violation, s_violation;
    logic             violation_sticky, s_violation_sticky;
    logic [7:0]       viol_count;
    logic [1:0]       s_viol_count;

    mod_counter_monitor #(.WIDTH(WIDTH), .MODULO(MOD), .BOUND(BOUND), .VCNT_W(8)) u_dut (
        .clock(clock), .reset(reset), .en(en), .up(up), .load(load),
        .load_value(load_value), .clear_viol(clear_viol),
        .count(count), .wrap(wrap), .load_err(load_err), .check_active(check_active),
        .violation(violation), .violation_sticky(violation_sticky), .viol_count(viol_count)
    );

    mod_counter_monitor #(.WIDTH(WIDTH), .MODULO(MOD), .BOUND(BOUND), .VCNT_W(2)) u_sat (
        .clock(clock), .reset(reset), .en(en), .up(up), .load(load),
        .load_value(load_value), .clear_viol(clear_viol),
        .count(s_count), .wrap(s_wrap), .load_err(s_load_err), .check_active(s_check_active),
        .violation(s_violation), .violation_sticky(s_violation_sticky), .viol_count(s_viol_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Model state: what the outputs must show right now.
    int m_count;
    bit m_wrap, m_lerr, m_prevnz, m_sticky, m_armed;
    int m_vc8, m_vc2;

    function automatic bit m_viol();
        return m_armed && (reset === 1'b1) && m_prevnz && (m_count >= BOUND);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_wrap = 0; m_lerr = 0; m_prevnz = 0;
        m_sticky = 0; m_vc8 = 0; m_vc2 = 0; m_armed = 1;
    endtask

    // Applies the rules to the inputs present at the clock edge.
    task automatic model_edge();
        bit v;
        int old;
        v   = m_viol();
        old = m_count;
        if (load) begin
            m_wrap = 0;
            if (int'(load_value) < MOD) begin m_count = int'(load_value); m_lerr = 0; end
            else begin m_count = 0; m_lerr = 1; end
        end else if (en) begin
            m_lerr = 0;
            if (up) begin m_wrap = (old == MOD - 1); m_count = (old + 1) % MOD; end
            else    begin m_wrap = (old == 0);       m_count = (old + MOD - 1) % MOD; end
        end else begin
            m_wrap = 0; m_lerr = 0;
        end
        m_prevnz = (old != 0);
        if (v) begin
            m_sticky = 1;
            m_vc8 = clear_viol ? 1 : ((m_vc8 < 255) ? m_vc8 + 1 : 255);
            m_vc2 = clear_viol ? 1 : ((m_vc2 < 3) ? m_vc2 + 1 : 3);
        end else if (clear_viol) begin
            m_sticky = 0; m_vc8 = 0; m_vc2 = 0;
        end
    endtask

    task automatic check_all();
        chk("count",        int'(count),            m_count);
        chk("wrap",         int'(wrap),             int'(m_wrap));
        chk("load_err",     int'(load_err),         int'(m_lerr));
        chk("check_active", int'(check_active),     int'(m_armed && reset === 1'b1));
        chk("violation",    int'(violation),        int'(m_viol()));
        chk("sticky",       int'(violation_sticky), int'(m_sticky));
        chk("viol_count",   int'(viol_count),       m_vc8);
        chk("sat_count",    int'(s_count),          m_count);
        chk("sat_viol_cnt", int'(s_viol_count),     m_vc2);
    endtask

    task automatic step(input bit l, input bit e, input bit u, input int lv, input bit cv);
        load = l; en = e; up = u; load_value = WIDTH'(lv); clear_viol = cv;
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        load = 0; en = 0; up = 0; load_value = '0; clear_viol = 0;
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_all();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        reset = 1'b1; en = 0; up = 0; load = 0; load_value = '0; clear_viol = 0;
        m_armed = 0; m_count = 0; m_prevnz = 0; m_wrap = 0; m_lerr = 0;
        m_sticky = 0; m_vc8 = 0; m_vc2 = 0;
        #2;
        total++;
        if (check_active === 1'b1) begin
            bad++;
            $display("FAIL pre_reset_check_active: got 1 expected not 1");
        end

        // Count up two full periods.
        do_reset();
        chk("lit_reset_count", int'(count), 0);
        for (int i = 0; i < 46; i++) step(0, 1, 1, 0, 0);
        chk("lit_up_count",  int'(count), 0);
        chk("lit_up_wrap",   int'(wrap), 1);
        chk("lit_up_vc",     int'(viol_count), 26);
        chk("lit_up_sticky", int'(violation_sticky), 1);
        chk("lit_up_vc_sat", int'(s_viol_count), 3);

        // Count down from reset.
        do_reset();
        step(0, 1, 0, 0, 0);
        chk("lit_dn_count", int'(count), 22);
        chk("lit_dn_wrap",  int'(wrap), 1);
        chk("lit_dn_viol0", int'(violation), 0);
        step(0, 1, 0, 0, 0);
        chk("lit_dn_count2", int'(count), 21);
        chk("lit_dn_viol1",  int'(violation), 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);

        // Load boundaries and out-of-range loads.
        step(1, 1, 1, 23, 0);
        chk("lit_ld23_err", int'(load_err), 1);
        step(1, 0, 0, 22, 0);
        chk("lit_ld22_count", int'(count), 22);
        chk("lit_ld22_err",   int'(load_err), 0);
        step(1, 1, 1, 30, 0);
        chk("lit_ld30_count", int'(count), 0);
        chk("lit_ld30_err",   int'(load_err), 1);
        step(1, 1, 1, 9, 0);
        chk("lit_ld9_count", int'(count), 9);
        chk("lit_ld9_err",   int'(load_err), 0);

        // Clear on a quiet cycle, then clear colliding with a violation.
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
        chk("lit_run_count", int'(count), 12);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("lit_clr_sticky", int'(violation_sticky), 0);
        chk("lit_clr_vc",     int'(viol_count), 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 1);
        chk("lit_clrv_sticky", int'(violation_sticky), 1);
        chk("lit_clrv_vc",     int'(viol_count), 1);
        for (int i = 0; i < 2; i++) step(0, 0, 1, 0, 0);

        // Asynchronous reset in the middle of a cycle at count 15.
        step(1, 0, 0, 15, 0);
        step(0, 0, 0, 0, 0);
        chk("lit_pre_async_count", int'(count), 15);
        #3;
        do_reset();
        chk("lit_async_count",  int'(count), 0);
        chk("lit_async_vc",     int'(viol_count), 0);
        chk("lit_async_active", int'(check_active), 1);
        chk("lit_async_viol",   int'(violation), 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
        chk("lit_resume_count", int'(count), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
